// File: rtl/bp_fe_bht_ctrl.sv
// Branch history table controller: clears the counter table after reset, then arbitrates the
// single SRAM port between predict reads and queued read-modify-write counter updates.
module bp_fe_bht_ctrl #(
  parameter int bht_idx_width_p = 9,
  parameter int ctr_width_p     = 2,
  parameter int upd_fifo_els_p  = 2,
  parameter int starve_limit_p  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       r_ready_o,
  output logic                       predict_v_o,
  output logic                       predict_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic                       w_taken_i,
  output logic                       w_ready_o,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [bht_idx_width_p-1:0] mem_addr_o,
  output logic [ctr_width_p-1:0]     mem_data_o,
  input  logic [ctr_width_p-1:0]     mem_data_i,
  output logic                       init_done_o
);

  localparam int ptr_w_lp    = (upd_fifo_els_p > 1) ? $clog2(upd_fifo_els_p) : 1;
  localparam int cnt_w_lp    = $clog2(upd_fifo_els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [ctr_width_p-1:0] ctr_max_lp     = '1;
  localparam logic [ctr_width_p-1:0] ctr_weak_nt_lp = ctr_max_lp >> 1;

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, UPD_RD = 2'd2, UPD_WR = 2'd3} state_e;

  function automatic logic [ctr_width_p-1:0] sat_update(input logic [ctr_width_p-1:0] ctr,
                                                        input logic taken);
    logic [ctr_width_p-1:0] res;
    if (taken) begin
      res = (ctr == ctr_max_lp) ? ctr : ctr + ctr_width_p'(1'b1);
    end else begin
      res = (ctr == '0) ? ctr : ctr - ctr_width_p'(1'b1);
    end
    return res;
  endfunction

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] ptr);
    return (ptr == ptr_w_lp'(upd_fifo_els_p - 1)) ? '0 : ptr + ptr_w_lp'(1'b1);
  endfunction

  state_e                     state_r, state_n_s;
  logic [bht_idx_width_p-1:0] init_cnt_r;
  logic                       init_done_r;
  logic                       predict_v_r;
  logic [starve_w_lp-1:0]     starve_cnt_r;
  logic [ctr_width_p-1:0]     rmw_ctr_r;
  logic [bht_idx_width_p-1:0] fifo_idx_r   [upd_fifo_els_p];
  logic                       fifo_taken_r [upd_fifo_els_p];
  logic [ptr_w_lp-1:0]        rd_ptr_r, wr_ptr_r;
  logic [cnt_w_lp-1:0]        fifo_cnt_r;

  logic fifo_nonempty_s, fifo_full_s, starved_s;
  logic r_ready_s, w_ready_s, read_grant_s, upd_start_s, push_s, pop_s;
  logic [bht_idx_width_p-1:0] head_idx_s;
  logic                       head_taken_s;

  assign fifo_nonempty_s = (fifo_cnt_r != '0);
  assign fifo_full_s     = (fifo_cnt_r == cnt_w_lp'(upd_fifo_els_p));
  assign starved_s       = fifo_nonempty_s & (starve_cnt_r == starve_w_lp'(starve_limit_p));
  assign r_ready_s       = ~reset_i & (state_r == IDLE) & ~starved_s;
  assign read_grant_s    = r_v_i & r_ready_s;
  // An update only claims the port in a cycle no read was granted.
  assign upd_start_s     = ~reset_i & (state_r == IDLE) & fifo_nonempty_s & ~read_grant_s;
  assign w_ready_s       = ~reset_i & init_done_r & ~fifo_full_s;
  assign push_s          = w_v_i & w_ready_s;
  assign pop_s           = ~reset_i & (state_r == UPD_WR);
  assign head_idx_s      = fifo_idx_r[rd_ptr_r];
  assign head_taken_s    = fifo_taken_r[rd_ptr_r];

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= INIT;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      INIT:    state_n_s = (init_cnt_r == '1) ? IDLE : INIT;
      IDLE:    state_n_s = upd_start_s ? UPD_RD : IDLE;
      UPD_RD:  state_n_s = UPD_WR;
      UPD_WR:  state_n_s = IDLE;
      default: state_n_s = INIT;
    endcase
  end

  // SRAM port drive; everything idles to zero while reset is held.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (~reset_i) begin
      case (state_r)
        INIT: begin
          mem_v_o    = 1'b1;
          mem_w_o    = 1'b1;
          mem_addr_o = init_cnt_r;
          mem_data_o = ctr_weak_nt_lp;
        end
        IDLE: begin
          if (read_grant_s) begin
            mem_v_o    = 1'b1;
            mem_addr_o = r_idx_i;
          end else if (upd_start_s) begin
            mem_v_o    = 1'b1;
            mem_addr_o = head_idx_s;
          end else begin
            mem_v_o    = 1'b0;
          end
        end
        UPD_WR: begin
          mem_v_o    = 1'b1;
          mem_w_o    = 1'b1;
          mem_addr_o = head_idx_s;
          mem_data_o = sat_update(rmw_ctr_r, head_taken_s);
        end
        default: begin
          mem_v_o    = 1'b0;
        end
      endcase
    end else begin
      mem_v_o    = 1'b0;
    end
  end

  assign r_ready_o   = r_ready_s;
  assign w_ready_o   = w_ready_s;
  assign init_done_o = ~reset_i & init_done_r;
  assign predict_v_o = ~reset_i & predict_v_r;
  assign predict_o   = ~reset_i & predict_v_r & mem_data_i[ctr_width_p-1];

  // Init sweep, prediction valid, starvation counter and captured RMW counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      init_cnt_r   <= '0;
      init_done_r  <= 1'b0;
      predict_v_r  <= 1'b0;
      starve_cnt_r <= '0;
      rmw_ctr_r    <= '0;
    end else begin
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + bht_idx_width_p'(1'b1);
      end
      if ((state_r == INIT) && (init_cnt_r == '1)) begin
        init_done_r <= 1'b1;
      end
      predict_v_r <= read_grant_s;
      if (upd_start_s) begin
        starve_cnt_r <= '0;
      end else if (read_grant_s && fifo_nonempty_s && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + starve_w_lp'(1'b1);
      end
      if (state_r == UPD_RD) begin
        rmw_ctr_r <= mem_data_i;
      end
    end
  end

  // Pending-update FIFO; reset drops every entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        fifo_idx_r[wr_ptr_r]   <= w_idx_i;
        fifo_taken_r[wr_ptr_r] <= w_taken_i;
        wr_ptr_r               <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + cnt_w_lp'(1'b1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - cnt_w_lp'(1'b1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule
